// File: rtl/ascii_loader.sv
// Buffers "Load Ascii" text downloads from hps_io and feeds them one byte at a
// time to the emulated ACIA receiver, with CR/LF clean-up and line pacing.
module ascii_loader #(
    parameter int FIFO_AW     = 4,
    parameter int CHAR_GAP    = 2000,
    parameter int LINE_GAP    = 500000,
    parameter int WAIT_MARGIN = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic [7:0] ioctl_index,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_read,
    output logic       loading
);

    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int GAP_MAX = (LINE_GAP > CHAR_GAP) ? LINE_GAP : CHAR_GAP;
    localparam int CNT_W   = $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, count, free;
    logic             empty, full, accept, keep, push, pop;
    logic             last_was_cr, ovf;
    logic [7:0]       wdata;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             rx_valid_next;
    logic [7:0]       rx_data_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign free  = (FIFO_AW+1)'(DEPTH) - count;

    // Line-ending normalisation and filtering ahead of the FIFO
    always_comb begin
        accept = ioctl_wr && ioctl_download && (ioctl_index == 8'd0);
        keep   = 1'b1;
        wdata  = {1'b0, ioctl_data[6:0]};
        if (ioctl_data == 8'h0A) begin
            if (last_was_cr) keep = 1'b0;
            else             wdata = 8'h0D;
        end else if (ioctl_data == 8'h00 || ioctl_data == 8'h1A) begin
            keep = 1'b0;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO may still take a push
    always_comb begin
        push = accept && keep && (!full || pop);
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_was_cr <= 1'b0;
            ovf         <= 1'b0;
            ioctl_wait  <= 1'b0;
            loading     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (accept && keep && full && !pop) ovf <= 1'b1;
            if (accept) last_was_cr <= (ioctl_data == 8'h0D);
            ioctl_wait <= (free <= (FIFO_AW+1)'(WAIT_MARGIN));
            loading    <= ioctl_download || !empty || (state != IDLE);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            rx_valid <= rx_valid_next;
            rx_data  <= rx_data_next;
        end
    end

    // Output pacing: present one byte, wait for the CPU read, then idle for the gap
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        rx_valid_next = rx_valid;
        rx_data_next  = rx_data;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    rx_data_next  = mem[rd_ptr[FIFO_AW-1:0]];
                    rx_valid_next = 1'b1;
                    state_next    = PRESENT;
                end
            end
            PRESENT: begin
                if (rx_read) begin
                    rx_valid_next = 1'b0;
                    cnt_next      = (rx_data == 8'h0D) ? CNT_W'(LINE_GAP - 1)
                                                       : CNT_W'(CHAR_GAP - 1);
                    state_next    = GAP;
                end
            end
            GAP: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
